io_unit: RTL and testbench



---
 rtl/io_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_io_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_unit.sv
// Purpose : memory-mapped I/O port block and edge-triggered interrupt responder for the control unit.
// Latency : bus pushes are combinational (0 cycles); port/register loads land on the next clk edge.
// Backpressure: none; every io_* strobe is accepted in its cycle and is exactly one cycle wide.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   io_read                 capture d_bus into port_out[io_addr] (+ port_wr_stb pulse)
//   io_write                load interrupt mask from d_bus[NUM_INTS-1:0], global enable from d_bus[15]
//   io_push                 drive port_in[io_addr] onto d_bus (+ port_rd_stb pulse next cycle)
//   io_addr_read            load handler address register from d_bus
//   io_addr[3:0]            port select; values >= NUM_PORTS are out of range
//   io_store_retaddr        load return address from d_bus, clear global enable
//   io_push_retaddr         drive return address onto d_bus, set global enable
//   io_push_ints            drive masked pending bits onto d_bus and acknowledge them
//   io_push_int_addr        drive handler address onto d_bus
//   io_interrupt            gie & |(pending & mask), combinational from registered state
//   d_bus[15:0]             shared tristate data bus, released unless a push strobe wins
//   irq[NUM_INTS-1:0]       interrupt request lines, rising edge is the event
//   port_in / port_out      16 bits per port, port i at [16i+15:16i]
//   port_wr_stb/port_rd_stb one-cycle per-port update / read pulses
//
// Build option: define IO_IRQ_SYNC_EN to put a 2-flop synchronizer in front of
// the irq edge detectors (needed when irq sources are asynchronous to clk).
// Without it, irq is edge-detected directly and must be synchronous to clk.

module io_unit #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_INTS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     io_read,
    input  logic                     io_write,
    input  logic                     io_push,
    input  logic                     io_addr_read,
    input  logic [3:0]               io_addr,
    input  logic                     io_store_retaddr,
    input  logic                     io_push_retaddr,
    input  logic                     io_push_ints,
    input  logic                     io_push_int_addr,
    output logic                     io_interrupt,
    inout  wire  [15:0]              d_bus,
    input  logic [NUM_INTS-1:0]      irq,
    input  logic [16*NUM_PORTS-1:0]  port_in,
    output logic [16*NUM_PORTS-1:0]  port_out,
    output logic [NUM_PORTS-1:0]     port_wr_stb,
    output logic [NUM_PORTS-1:0]     port_rd_stb
);

    localparam logic [4:0] PORTS_LIM = 5'(NUM_PORTS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [16*NUM_PORTS-1:0] port_out_q, port_out_d;
    logic [NUM_PORTS-1:0]    port_wr_stb_q, port_wr_stb_d;
    logic [NUM_PORTS-1:0]    port_rd_stb_q, port_rd_stb_d;
    logic [NUM_INTS-1:0]     mask_q, mask_d;
    logic                    gie_q, gie_d;
    logic [NUM_INTS-1:0]     pending_q, pending_d;
    logic [15:0]             retaddr_q, retaddr_d;
    logic [15:0]             int_addr_q, int_addr_d;
    logic [NUM_INTS-1:0]     irq_hist_q, irq_hist_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                    addr_in_range;
    logic                    win_push;
    logic                    win_retaddr;
    logic                    win_ints;
    logic                    win_int_addr;
    logic                    bus_oe;
    logic [15:0]             bus_dat;
    logic [15:0]             port_sel;
    logic [NUM_INTS-1:0]     pend_masked;
    logic [NUM_INTS-1:0]     irq_cond;
    logic [NUM_INTS-1:0]     irq_rise;
    logic [NUM_INTS-1:0]     ack_clr;

    assign addr_in_range = ({1'b0, io_addr} < PORTS_LIM);

    // Only one push may own the bus; the fixed priority also decides whose
    // side effects (gie set, pending acknowledge) take place.
    assign win_push     = io_push;
    assign win_retaddr  = io_push_retaddr  & ~io_push;
    assign win_ints     = io_push_ints     & ~io_push & ~io_push_retaddr;
    assign win_int_addr = io_push_int_addr & ~io_push & ~io_push_retaddr & ~io_push_ints;

    assign pend_masked  = pending_q & mask_q;

    // Input port mux; out-of-range addresses read back as zero.
    always_comb begin
        port_sel = 16'h0000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (io_addr == 4'(i)) begin
                port_sel = port_in[16*i +: 16];
            end
        end
    end

    always_comb begin
        bus_dat = 16'h0000;
        if (win_push) begin
            bus_dat = port_sel;
        end else if (win_retaddr) begin
            bus_dat = retaddr_q;
        end else if (win_ints) begin
            bus_dat = 16'(pend_masked);
        end else if (win_int_addr) begin
            bus_dat = int_addr_q;
        end
    end

    // rst_n gates the enable so the bus is released the instant reset asserts,
    // even if a push strobe is still high.
    assign bus_oe = rst_n & (io_push | io_push_retaddr | io_push_ints | io_push_int_addr);
    assign d_bus  = bus_oe ? bus_dat : 16'bz;

    // ------------------------------------------------------------------
    // Interrupt request conditioning and edge detection
    // ------------------------------------------------------------------
`ifdef IO_IRQ_SYNC_EN
    logic [NUM_INTS-1:0] irq_sync1_q, irq_sync1_d;
    logic [NUM_INTS-1:0] irq_sync2_q, irq_sync2_d;

    always_comb begin
        irq_sync1_d = irq;
        irq_sync2_d = irq_sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync1_q <= '0;
            irq_sync2_q <= '0;
        end else begin
            irq_sync1_q <= irq_sync1_d;
            irq_sync2_q <= irq_sync2_d;
        end
    end

    assign irq_cond = irq_sync2_q;
`else
    assign irq_cond = irq;
`endif

    // Level is not remembered: a line held high produces a single rise.
    assign irq_hist_d = irq_cond;
    assign irq_rise   = irq_cond & ~irq_hist_q;

    // Acknowledge clears exactly the bits that were driven on the bus; a
    // fresh rise in the same cycle is OR'ed in afterwards so the set wins.
    assign ack_clr = win_ints ? pend_masked : '0;

    always_comb begin
        pending_d = (pending_q & ~ack_clr) | irq_rise;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        mask_d     = mask_q;
        gie_d      = gie_q;
        retaddr_d  = retaddr_q;
        int_addr_d = int_addr_q;

        if (io_write) begin
            mask_d = d_bus[NUM_INTS-1:0];
            gie_d  = d_bus[15];
        end
        if (io_addr_read) begin
            int_addr_d = d_bus;
        end
        // Entering a handler: storing the return address disables further
        // interrupts, overriding a same-cycle enable write.
        if (io_store_retaddr) begin
            retaddr_d = d_bus;
            gie_d     = 1'b0;
        end
        // Returning from a handler re-enables interrupts.
        if (win_retaddr) begin
            gie_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output ports and their strobes
    // ------------------------------------------------------------------
    always_comb begin
        port_out_d    = port_out_q;
        port_wr_stb_d = '0;
        port_rd_stb_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (io_read && addr_in_range && (io_addr == 4'(i))) begin
                port_out_d[16*i +: 16] = d_bus;
                port_wr_stb_d[i]       = 1'b1;
            end
            if (win_push && addr_in_range && (io_addr == 4'(i))) begin
                port_rd_stb_d[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_out_q    <= '0;
            port_wr_stb_q <= '0;
            port_rd_stb_q <= '0;
            mask_q        <= '0;
            gie_q         <= 1'b0;
            pending_q     <= '0;
            retaddr_q     <= 16'h0000;
            int_addr_q    <= 16'h0000;
            irq_hist_q    <= '0;
        end else begin
            port_out_q    <= port_out_d;
            port_wr_stb_q <= port_wr_stb_d;
            port_rd_stb_q <= port_rd_stb_d;
            mask_q        <= mask_d;
            gie_q         <= gie_d;
            pending_q     <= pending_d;
            retaddr_q     <= retaddr_d;
            int_addr_q    <= int_addr_d;
            irq_hist_q    <= irq_hist_d;
        end
    end

    assign port_out     = port_out_q;
    assign port_wr_stb  = port_wr_stb_q;
    assign port_rd_stb  = port_rd_stb_q;
    assign io_interrupt = gie_q & (|pend_masked);

endmodule

// File: tb/tb_io_unit.sv
module tb_io_unit;

    localparam int NP = 4;
    localparam int NI = 8;
`ifdef IO_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            io_read, io_write, io_push, io_addr_read;
    logic [3:0]      io_addr;
    logic            io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr;
    logic            io_interrupt;
    wire  [15:0]     d_bus;
    logic [NI-1:0]   irq;
    logic [16*NP-1:0] port_in;
    logic [16*NP-1:0] port_out;
    logic [NP-1:0]   port_wr_stb, port_rd_stb;

    logic            tb_en;
    logic [15:0]     tb_dat;
    logic [15:0]     pin [NP];

    assign d_bus = tb_en ? tb_dat : 16'bz;

    for (genvar g = 0; g < NP; g++) begin : g_pin
        assign port_in[16*g +: 16] = pin[g];
    end

    io_unit #(.NUM_PORTS(NP), .NUM_INTS(NI)) dut (
        .clk(clk), .rst_n(rst_n),
        .io_read(io_read), .io_write(io_write), .io_push(io_push),
        .io_addr_read(io_addr_read), .io_addr(io_addr),
        .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
        .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
        .io_interrupt(io_interrupt), .d_bus(d_bus), .irq(irq),
        .port_in(port_in), .port_out(port_out),
        .port_wr_stb(port_wr_stb), .port_rd_stb(port_rd_stb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef enum logic [3:0] {
        OP_IDLE, OP_RD, OP_WR, OP_PUSH, OP_AREAD, OP_STRET, OP_PRET, OP_PINTS, OP_PIADDR
    } op_e;

    task automatic set_op(input op_e op, input logic [3:0] a, input logic [15:0] d);
        io_read          = (op == OP_RD);
        io_write         = (op == OP_WR);
        io_push          = (op == OP_PUSH);
        io_addr_read     = (op == OP_AREAD);
        io_store_retaddr = (op == OP_STRET);
        io_push_retaddr  = (op == OP_PRET);
        io_push_ints     = (op == OP_PINTS);
        io_push_int_addr = (op == OP_PIADDR);
        io_addr          = a;
        tb_en            = !(op == OP_PUSH || op == OP_PRET || op == OP_PINTS || op == OP_PIADDR);
        tb_dat           = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        op_e         op;
        logic [3:0]  addr;
        logic [15:0] dat;
        logic [15:0] e_bus;
        logic        e_int;
        logic [3:0]  e_wr;
        logic [3:0]  e_rd;
        logic [63:0] e_pout;
    } vec_t;

    function automatic vec_t mk(op_e op, logic [3:0] a, logic [15:0] d, logic [15:0] eb,
                                logic ei, logic [3:0] ew, logic [3:0] er, logic [63:0] ep);
        vec_t v;
        v.op = op; v.addr = a; v.dat = d; v.e_bus = eb;
        v.e_int = ei; v.e_wr = ew; v.e_rd = er; v.e_pout = ep;
        return v;
    endfunction

    // Reference model state (behavioural)
    logic [15:0]   m_pout [NP];
    logic [NP-1:0] m_wr, m_rd;
    logic [NI-1:0] m_mask, m_pend;
    logic          m_gie;
    logic [15:0]   m_ret, m_iaddr;
    logic [NI-1:0] m_samp [4];   // m_samp[0] = irq sampled at the latest edge

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_pout[i] = 16'h0;
        for (int i = 0; i < 4; i++) m_samp[i] = '0;
        m_wr = '0; m_rd = '0; m_mask = '0; m_pend = '0;
        m_gie = 1'b0; m_ret = 16'h0; m_iaddr = 16'h0;
    endtask

    function automatic logic [63:0] model_pout();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[16*i +: 16] = m_pout[i];
        return r;
    endfunction

    function automatic logic [15:0] model_bus();
        if (io_push)               return (io_addr < NP) ? pin[io_addr[1:0]] : 16'h0000;
        else if (io_push_retaddr)  return m_ret;
        else if (io_push_ints)     return 16'(m_pend & m_mask);
        else if (io_push_int_addr) return m_iaddr;
        else                       return tb_dat;
    endfunction

    // Advance the model across one rising edge with the current inputs.
    task automatic model_edge(input logic [15:0] bus);
        logic [NI-1:0] clr, rise;
        logic          in_rng;
        in_rng = (io_addr < NP);
        clr = (io_push_ints && !io_push && !io_push_retaddr) ? (m_pend & m_mask) : '0;
        for (int i = 3; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = irq;
        rise = m_samp[LAT-1] & ~m_samp[LAT];
        m_wr = '0;
        m_rd = '0;
        if (io_read && in_rng) begin
            m_pout[io_addr[1:0]] = bus;
            m_wr[io_addr[1:0]] = 1'b1;
        end
        if (io_push && in_rng) m_rd[io_addr[1:0]] = 1'b1;
        if (io_write) begin
            m_mask = bus[NI-1:0];
            m_gie  = bus[15];
        end
        if (io_addr_read) m_iaddr = bus;
        if (io_store_retaddr) begin
            m_ret = bus;
            m_gie = 1'b0;
        end
        if (io_push_retaddr && !io_push) m_gie = 1'b1;
        m_pend = (m_pend & ~clr) | rise;
    endtask

    vec_t tbl [18];
    localparam logic [63:0] P2 = 64'h0000_BEEF_0000_0000;

    initial begin
        pin[0] = 16'hA000; pin[1] = 16'h1234; pin[2] = 16'hC0DE; pin[3] = 16'h0F0F;
        irq = '0;
        set_op(OP_IDLE, 4'd0, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("rst_int", {63'b0, io_interrupt}, 64'd0);
        chk("rst_pout", port_out, 64'd0);
        chk("rst_stb", {56'b0, port_wr_stb, port_rd_stb}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, 64'd0);
        tbl[1]  = mk(OP_RD,     4'd2, 16'hBEEF, 16'hBEEF, 1'b0, 4'b0000, 4'b0000, 64'd0);
        tbl[2]  = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0100, 4'b0000, P2);
        tbl[3]  = mk(OP_PUSH,   4'd1, 16'h0000, 16'h1234, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[4]  = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0010, P2);
        tbl[5]  = mk(OP_PUSH,   4'd9, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[6]  = mk(OP_IDLE,   4'd0, 16'h5555, 16'h5555, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[7]  = mk(OP_RD,     4'd9, 16'hDEAD, 16'hDEAD, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[8]  = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[9]  = mk(OP_PIADDR, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[10] = mk(OP_AREAD,  4'd0, 16'h0300, 16'h0300, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[11] = mk(OP_PIADDR, 4'd0, 16'h0000, 16'h0300, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[12] = mk(OP_WR,     4'd0, 16'h8005, 16'h8005, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[13] = mk(OP_PRET,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[14] = mk(OP_PUSH,   4'd3, 16'h0000, 16'h0F0F, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[15] = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 4'b1000, P2);
        tbl[16] = mk(OP_RD,     4'd0, 16'h1111, 16'h1111, 1'b0, 4'b0000, 4'b0000, P2);
        tbl[17] = mk(OP_IDLE,   4'd0, 16'h0000, 16'h0000, 1'b0, 4'b0001, 4'b0000,
                     64'h0000_BEEF_0000_1111);

        for (int i = 0; i < 18; i++) begin
            set_op(tbl[i].op, tbl[i].addr, tbl[i].dat);
            #1;
            chk($sformatf("tbl%0d_bus", i), {48'b0, d_bus}, {48'b0, tbl[i].e_bus});
            chk($sformatf("tbl%0d_int", i), {63'b0, io_interrupt}, {63'b0, tbl[i].e_int});
            chk($sformatf("tbl%0d_wr", i), {60'b0, port_wr_stb}, {60'b0, tbl[i].e_wr});
            chk($sformatf("tbl%0d_rd", i), {60'b0, port_rd_stb}, {60'b0, tbl[i].e_rd});
            chk($sformatf("tbl%0d_pout", i), port_out, tbl[i].e_pout);
            tick();
        end
        // Now: gie=1, mask=0x05, pending=0, retaddr=0, int_addr=0x0300

        // ---------------- irq latency and acknowledge ----------------
        set_op(OP_IDLE, 4'd0, 16'h0000);
        irq = 8'h01;
        #1;
        chk("irqA_pre", {63'b0, io_interrupt}, 64'd0);
        for (int i = 0; i < LAT; i++) begin
            tick();
            #1;
            chk($sformatf("irqA_edge%0d", i), {63'b0, io_interrupt}, {63'b0, (i == LAT - 1)});
        end
        set_op(OP_PINTS, 4'd0, 16'h0000);
        #1;
        chk("ackA_bus", {48'b0, d_bus}, 64'h0001);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("ackA_int", {63'b0, io_interrupt}, 64'd0);
        irq = 8'h00;
        for (int i = 0; i <= LAT; i++) tick();

        // ---------------- masked edge, then unmask ----------------
        irq = 8'h02;
        for (int i = 0; i <= LAT; i++) tick();
        #1;
        chk("maskB_low", {63'b0, io_interrupt}, 64'd0);
        set_op(OP_WR, 4'd0, 16'h8002);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("maskB_high", {63'b0, io_interrupt}, 64'd1);

        // ---------------- return address / gie ordering ----------------
        set_op(OP_STRET, 4'd0, 16'h0042);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("retC_gie_off", {63'b0, io_interrupt}, 64'd0);
        set_op(OP_PRET, 4'd0, 16'h0000);
        #1;
        chk("retC_bus", {48'b0, d_bus}, 64'h0042);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("retC_gie_on", {63'b0, io_interrupt}, 64'd1);

        set_op(OP_WR, 4'd0, 16'h8002);
        io_store_retaddr = 1'b1;
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("store_wins", {63'b0, io_interrupt}, 64'd0);
        set_op(OP_PRET, 4'd0, 16'h0000);
        #1;
        chk("store_ret_bus", {48'b0, d_bus}, 64'h8002);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("store_reen", {63'b0, io_interrupt}, 64'd1);

        // ---------------- new edge coincides with acknowledge ----------------
        set_op(OP_WR, 4'd0, 16'h8003);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        irq = 8'h03;
        for (int i = 0; i < LAT; i++) tick();
        irq = 8'h02;
        for (int i = 0; i <= LAT; i++) tick();
        irq = 8'h03;
        for (int i = 0; i < LAT - 1; i++) tick();
        set_op(OP_PINTS, 4'd0, 16'h0000);
        #1;
        chk("setD_bus", {48'b0, d_bus}, 64'h0003);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("setD_int", {63'b0, io_interrupt}, 64'd1);
        set_op(OP_PINTS, 4'd0, 16'h0000);
        #1;
        chk("setD_bus2", {48'b0, d_bus}, 64'h0001);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("setD_int2", {63'b0, io_interrupt}, 64'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        irq = 8'h00;
        set_op(OP_PUSH, 4'd1, 16'h0000);
        tb_en = 1'b1;
        #1;
        chk("rstE_bus", {48'b0, d_bus}, 64'h0000);
        chk("rstE_pout", port_out, 64'd0);
        chk("rstE_int", {63'b0, io_interrupt}, 64'd0);
        tick();
        chk("rstE_bus2", {48'b0, d_bus}, 64'h0000);
        chk("rstE_stb", {56'b0, port_wr_stb, port_rd_stb}, 64'd0);
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #2;
        rst_n = 1'b1;
        tick();
        set_op(OP_WR, 4'd0, 16'h80FF);
        tick();
        set_op(OP_IDLE, 4'd0, 16'h0000);
        #1;
        chk("rstE_pend_clr", {63'b0, io_interrupt}, 64'd0);

        // ---------------- randomized run against the model ----------------
        rst_n = 1'b0;
        irq = '0;
        set_op(OP_IDLE, 4'd0, 16'h0000);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] eb;
            logic        p, pr, pi, pa;
            pin[$urandom_range(0, NP - 1)] = 16'($urandom);
            irq = irq ^ (NI'($urandom) & NI'($urandom) & NI'($urandom));
            p  = ($urandom_range(0, 9) == 0);
            pr = ($urandom_range(0, 11) == 0);
            pi = ($urandom_range(0, 5) == 0);
            pa = ($urandom_range(0, 11) == 0);
            io_push          = p;
            io_push_retaddr  = pr;
            io_push_ints     = pi;
            io_push_int_addr = pa;
            io_read          = ($urandom_range(0, 4) == 0);
            io_write         = ($urandom_range(0, 6) == 0) && !pr;
            io_addr_read     = ($urandom_range(0, 9) == 0);
            io_store_retaddr = ($urandom_range(0, 9) == 0) && !pr;
            io_addr          = 4'($urandom_range(0, 5));
            tb_en            = !(p || pr || pi || pa);
            tb_dat           = 16'($urandom);
            if ($urandom_range(0, 1) == 1) tb_dat[15] = 1'b1;
            #1;
            eb = model_bus();
            chk("rnd_bus", {48'b0, d_bus}, {48'b0, eb});
            chk("rnd_int", {63'b0, io_interrupt}, {63'b0, (m_gie & (|(m_pend & m_mask)))});
            chk("rnd_wr", {60'b0, port_wr_stb}, {60'b0, m_wr});
            chk("rnd_rd", {60'b0, port_rd_stb}, {60'b0, m_rd});
            chk("rnd_pout", port_out, model_pout());
            model_edge(eb);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
